// File: rtl/fifo_sched.sv
// fifo_sched: round-robin write/read arbiter in front of a single-port block FIFO.
// A 2-entry output buffer with read credits hides the FIFO's registered read latency.
`timescale 1ns/1ps
module fifo_sched #(
  parameter int DATA_WIDTH = 128,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  fifo_write_e,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  output logic                  fifo_read_e,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_full,
  input  logic                  fifo_empty,
  input  logic                  fifo_ready,
  output logic [CNT_WIDTH-1:0]  words_in,
  output logic [CNT_WIDTH-1:0]  words_out
);

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_t;

  typedef enum logic {
    GRANT_WRITE = 1'b0,
    GRANT_READ  = 1'b1
  } grant_t;

  buf_state_t            buf_state;
  grant_t                last_grant;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] buf_head;
  logic [DATA_WIDTH-1:0] buf_tail;
  logic [1:0]            buf_cnt;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  wr_grant;
  logic                  rd_grant;
  logic                  buf_push;
  logic                  buf_pop;

  always_comb begin
    buf_cnt = 2'd0;
    case (buf_state)
      BUF_ONE: buf_cnt = 2'd1;
      BUF_TWO: buf_cnt = 2'd2;
      default: buf_cnt = 2'd0;
    endcase
  end

  // A pop is only issued when the word it returns is guaranteed a buffer slot;
  // holding off while a pop is in flight covers the lag of the registered empty flag.
  assign wr_ok = s_valid & ~fifo_full & fifo_ready & ~reset;
  assign rd_ok = ~fifo_empty & fifo_ready & ~inflight & ~reset &
                 ((buf_cnt + {1'b0, inflight}) < 2'd2);

  always_comb begin
    wr_grant = wr_ok;
    rd_grant = rd_ok;
    if (wr_ok && rd_ok) begin
      wr_grant = (last_grant == GRANT_READ);
      rd_grant = (last_grant == GRANT_WRITE);
    end
  end

  assign s_ready      = wr_grant;
  assign fifo_write_e = wr_grant;
  assign fifo_read_e  = rd_grant;
  assign fifo_wdata   = s_data;
  assign buf_push     = inflight;
  assign buf_pop      = m_valid & m_ready;
  assign m_data       = buf_head;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= GRANT_READ;
      inflight   <= 1'b0;
      words_in   <= '0;
      words_out  <= '0;
    end else begin
      if (wr_grant) begin
        last_grant <= GRANT_WRITE;
      end else if (rd_grant) begin
        last_grant <= GRANT_READ;
      end
      inflight <= rd_grant;
      if (s_valid && s_ready) begin
        words_in <= words_in + CNT_WIDTH'(1);
      end
      if (buf_pop) begin
        words_out <= words_out + CNT_WIDTH'(1);
      end
    end
  end

  // Output buffer: head is always the oldest word, tail only used in BUF_TWO.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_state <= BUF_EMPTY;
      m_valid   <= 1'b0;
      buf_head  <= '0;
      buf_tail  <= '0;
    end else begin
      case (buf_state)
        BUF_EMPTY: begin
          if (buf_push) begin
            buf_head  <= fifo_rdata;
            buf_state <= BUF_ONE;
            m_valid   <= 1'b1;
          end
        end
        BUF_ONE: begin
          case ({buf_push, buf_pop})
            2'b10: begin
              buf_tail  <= fifo_rdata;
              buf_state <= BUF_TWO;
            end
            2'b01: begin
              buf_state <= BUF_EMPTY;
              m_valid   <= 1'b0;
            end
            2'b11: buf_head <= fifo_rdata;
            default: buf_state <= BUF_ONE;
          endcase
        end
        BUF_TWO: begin
          if (buf_pop) begin
            buf_head  <= buf_tail;
            buf_state <= BUF_ONE;
          end
        end
        default: begin
          buf_state <= BUF_EMPTY;
          m_valid   <= 1'b0;
        end
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (reset) !(buf_push && buf_state == BUF_TWO));

endmodule

// File: doc/fifo_sched.md
# fifo_sched

Scheduler and stream adapter for the single-port block FIFO (`fifo`) used between the AXI-stream input and the AES core. It converts an upstream valid/ready stream into `fifo_write_e` operations and `fifo_read_e` operations into a downstream valid/ready stream. Because the FIFO accepts at most one operation per cycle, the block arbitrates between writes and reads round-robin. A 2-entry output buffer with read-credit accounting hides the FIFO's registered read latency and never drops a word.

## Interface
- `DATA_WIDTH`, 128, word width (one AES block)
- `CNT_WIDTH`, 32, width of the accepted/delivered word counters
- `clk`  in  1  single clock; all logic on posedge
- `reset`  in  1  synchronous, active-high reset
- `s_valid`  in  1  upstream word valid
- `s_data`  in  DATA_WIDTH  upstream word
- `s_ready`  out  1  upstream word accepted this cycle (write granted)
- `m_valid`  out  1  downstream word valid
- `m_data`  out  DATA_WIDTH  downstream word (output buffer head)
- `m_ready`  in  1  downstream accepts
- `fifo_write_e`  out  1  FIFO write strobe
- `fifo_wdata`  out  DATA_WIDTH  FIFO write data, equal to `s_data`
- `fifo_read_e`  out  1  FIFO pop strobe
- `fifo_rdata`  in  DATA_WIDTH  FIFO read data, valid the cycle after a pop
- `fifo_full`, `fifo_empty`, `fifo_ready`  in  1 each  FIFO flags, registered, reflecting all ops up to the previous edge
- `words_in`  out  CNT_WIDTH  count of accepted upstream words
- `words_out`  out  CNT_WIDTH  count of delivered downstream words

## Operation
- Eligibility, evaluated combinationally each cycle:
  - wr_ok = `s_valid` & !`fifo_full` & `fifo_ready`
  - rd_ok = !`fifo_empty` & `fifo_ready` & (buf_cnt + inflight < 2) & !inflight_pop
- Arbiter: at most one of `fifo_write_e` and `fifo_read_e` is high in any cycle.
  - If only one side is eligible, that side is granted.
  - If both are eligible, grant goes to the side not granted last time. The `last_grant` register updates only on a grant and resets to "read", so the first tie goes to write.
- `s_ready` = `fifo_write_e` = write grant. `fifo_wdata` = `s_data` combinationally.
- Read path:
  - A pop in cycle N sets `inflight`.
  - At the end of cycle N+1, `fifo_rdata` is captured into the output buffer tail and `inflight` clears.
  - A second pop is not issued while `inflight` is set. This guards against `fifo_empty` lag.
- Output buffer: 2-entry FIFO with states EMPTY, ONE, TWO.
  - `m_valid` = state != EMPTY. `m_data` = head entry.
  - Pop on `m_valid` & `m_ready`. Push on capture.
  - Simultaneous push and pop keeps the state unchanged and preserves order.
  - A push in TWO is impossible by credit and is covered by an assertion.
- Counters:
  - `words_in` increments on `s_valid` & `s_ready`.
  - `words_out` increments on `m_valid` & `m_ready`.
  - Both wrap modulo 2^CNT_WIDTH.
- Ordering: words leave `m_data` in exactly the order accepted on `s_data`.

## Timing
- Reset values: `s_ready`, `fifo_write_e`, `fifo_read_e`, `m_valid` = 0; `m_data` = 0; `words_in` = `words_out` = 0; buffer EMPTY; `inflight` = 0; `last_grant` = read.
- Reset is applied mid-operation without warning.
  - All block state clears on the next edge; no strobes are issued during reset.
  - An in-flight read is discarded. The FIFO is reset in parallel by the same `reset`.
- Minimum latency with an empty FIFO and `fifo_ready` held high:
  - word accepted in cycle 0
  - pop issued in cycle 1
  - `m_valid` high in cycle 3
- Throughput is at most 1 FIFO operation per cycle, further limited by `fifo_ready`. Sustained concurrent traffic alternates write/read.
- `m_ready` low does not stall writes. Writes continue until `fifo_full`.
- `fifo_full`: `s_ready` = 0 until the flag drops. The word is held upstream and is not lost.
- `fifo_empty`: no pop is issued. `m_valid` drains the remaining buffer entries.
- `fifo_ready` low: no strobe of either kind is issued that cycle.

## Test plan
- Reset: drive `reset` = 1 for 2 cycles with `s_valid` = 1 → all outputs 0, no strobes, `words_in` = 0.
- Single word: write 0x0123…CDEF at cycle 0 with `m_ready` = 1 → `m_valid` high at cycle 3 with the same data; `words_in` = `words_out` = 1.
- Fill (FIFO DEPTH = 11): `m_ready` = 0, push 20 random words.
  - Expect exactly 13 accepted: 11 in the FIFO plus 2 in the buffer, then `s_ready` = 0 while `fifo_full`.
  - Release `m_ready` → all 13 delivered in order, then the remaining 7 flow through.
- Arbitration: `s_valid` and `m_ready` held high, 50 random words → no cycle has both strobes high, strobes alternate once both sides are eligible, output matches the scoreboard queue.
- Backpressure: `m_ready` random at 50%, `fifo_ready` forced low on random cycles, 200 words → no strobe issued while `fifo_ready` = 0, order preserved, final `words_out` = 200.
- Reset mid-stream: assert `reset` one cycle after a pop with `inflight` = 1 → `m_valid` = 0 next cycle, the captured word is discarded, and a fresh single-word test then passes.
